arb_requester: RTL
==================

// Module: arb_requester
// PURPOSE
// - Requester-side agent for the arb_if request/grant protocol; drives request[], consumes grant[].
// - Per channel: accepts a job (beat count), holds request until granted, runs the burst, releases.
// - Sits between local job sources and the arbiter; checks grant legality and flags protocol errors.
// PARAMETERS
// - NUM_REQ   2   number of request/grant channels (matches arb_if request/grant width)
// - LEN_W     4   width of job_len; burst = job_len+1 beats (1..2**LEN_W)
// - MIN_GAP   1   idle cycles with request low after a burst before re-request (>=1)
// - TIMEOUT   16  max cycles in REQ without grant (used only with REQ_TIMEOUT_EN)
// PORTS
// - clk          in   1              clock, all logic on posedge
// - rst          in   1              asynchronous, active-high reset
// - job_valid    in   NUM_REQ        per-channel job offer
// - job_len      in   NUM_REQ*LEN_W  per-channel beats-1, slice i = [i*LEN_W +: LEN_W]
// - job_ready    out  NUM_REQ        channel i in IDLE, can accept a job
// - request      out  NUM_REQ        to arbiter, registered
// - grant        in   NUM_REQ        from arbiter, one-hot or zero
// - beat_en      out  NUM_REQ        channel i transfers one beat this cycle
// - done         out  NUM_REQ        1-cycle pulse coincident with the last beat
// - proto_err    out  1              sticky illegal-grant flag
// - timeout_err  out  NUM_REQ        sticky per-channel timeout flag (REQ_TIMEOUT_EN only)
// BEHAVIOUR
// - Reset: all FSMs IDLE, counters 0; request, beat_en, done, proto_err, timeout_err = 0; job_ready = 1.
// - job_ready[i] = (state_i==IDLE), decoded from state register, no input path.
// - Per-channel FSM IDLE -> REQ -> BUSY -> GAP -> IDLE; channels fully independent.
// - IDLE: job_valid&&job_ready -> capture job_len into rem_i, go REQ; request[i]=1 next cycle.
// - REQ: request[i]=1; grant[i] sampled 1 -> BUSY. No beat in the grant-sampling cycle.
// - BUSY: request[i]=1, beat_en[i]=grant[i]; each beat with rem_i>0 decrements rem_i.
// - Last beat (beat_en && rem_i==0): done[i]=1 same cycle, next state GAP, request[i]=0 next cycle.
// - Preemption: grant[i]=0 in BUSY before last beat -> REQ, rem_i kept, request stays 1, resumes on re-grant.
// - GAP: request[i]=0 for MIN_GAP cycles (counter), then IDLE.
// - Latency: job accept at cycle N -> request at N+1; grant seen at G -> first beat at G+1;
//   burst of L+1 beats uninterrupted: request falls cycle after done.
// - proto_err set (sticky) if: grant has >1 bit set; or grant[i]=1 while state_i in IDLE or GAP
//   (excluding the first GAP cycle, allowing arbiter one cycle to drop grant).
// - Illegal grant does not alter FSMs; beat_en only ever asserted in BUSY.
// - Reset mid-burst: async clears all state immediately; partial bursts discarded, no done.
// - rem_i width LEN_W; job_len all-ones = 2**LEN_W beats, no overflow.
// CONFIGURATION
// - REQ_TIMEOUT_EN defined: per-channel wait counter counts REQ cycles (reset on entry to REQ,
//   also on preemption re-entry); reaching TIMEOUT -> timeout_err[i]=1 sticky, request drops, FSM -> GAP,
//   job abandoned, no done.
// - REQ_TIMEOUT_EN undefined: no counter, REQ waits indefinitely; timeout_err tied 0.
// TESTING
// - Reset then job ch0 len=3, grant[0] held -> request[0] 1 cycle after accept, 4 beat_en, done on 4th,
//   request[0] low next cycle, job_ready[0] back after MIN_GAP=1.
// - Both channels jobs len=0 same cycle, grant 01 then 10 -> ch0 1 beat+done, then ch1 1 beat+done; proto_err=0.
// - ch0 len=5, grant dropped after 2 beats for 3 cycles then restored -> request[0] stays 1, 4 more beats, done once.
// - grant=11 for one cycle, or grant[1]=1 while ch1 IDLE -> proto_err=1, stays 1 until rst.
// - rst pulsed mid-burst (ch0 beat 2 of 8) -> request/beat_en/done 0 immediately, job_ready=11.
// - REQ_TIMEOUT_EN, TIMEOUT=16, grant never given -> request[0] drops after 16 REQ cycles, timeout_err[0]=1, no done.

Source files
------------

// File: rtl/arb_requester.sv
// Requester-side agent for the arb_if request/grant protocol.
// Each channel accepts a job (beats-1), raises request until granted, streams the burst while
// the grant is held, then keeps request low for MIN_GAP cycles before it can accept again.
// Illegal grants (multi-hot, or aimed at an idle/settled channel) set a sticky proto_err_o.
// Optional feature: define REQ_TIMEOUT_EN to abandon jobs that wait TIMEOUT cycles in REQ.
module arb_requester #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned LEN_W   = 4,
   parameter int unsigned MIN_GAP = 1,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         job_valid_i,
   input  logic [NUM_REQ*LEN_W-1:0]   job_len_i,
   output logic [NUM_REQ-1:0]         job_ready_o,
   output logic [NUM_REQ-1:0]         request_o,
   input  logic [NUM_REQ-1:0]         grant_i,
   output logic [NUM_REQ-1:0]         beat_en_o,
   output logic [NUM_REQ-1:0]         done_o,
   output logic                       proto_err_o,
   output logic [NUM_REQ-1:0]         timeout_err_o
);

   typedef enum logic [1:0] {StIdle, StReq, StBusy, StGap} state_e;

   localparam int unsigned GapW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

   if (NUM_REQ < 1 || MIN_GAP < 1 || TIMEOUT < 1) begin : g_param_err
      $error("arb_requester: NUM_REQ, MIN_GAP and TIMEOUT must all be >= 1");
   end

   state_e             state_q [NUM_REQ];
   state_e             state_d [NUM_REQ];
   logic [LEN_W-1:0]   rem_q   [NUM_REQ];
   logic [LEN_W-1:0]   rem_d   [NUM_REQ];
   logic [GapW-1:0]    gap_q   [NUM_REQ];
   logic [GapW-1:0]    gap_d   [NUM_REQ];
   logic [NUM_REQ-1:0] request_q, request_d;
   logic               proto_err_q, proto_err_d;
   logic [NUM_REQ-1:0] timed_out;
   logic               multi_hot;

   // Clearing the lowest set bit leaves something only if more than one bit was set.
   assign multi_hot = |(grant_i & (grant_i - NUM_REQ'(1)));

`ifdef REQ_TIMEOUT_EN
   localparam int unsigned WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [WaitW-1:0]   wait_q [NUM_REQ];
   logic [WaitW-1:0]   wait_d [NUM_REQ];
   logic [NUM_REQ-1:0] tout_q, tout_d;

   // Count ungranted REQ cycles; held at zero elsewhere so every entry to REQ starts fresh.
   always_comb begin
      tout_d    = tout_q;
      timed_out = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         wait_d[i] = '0;
         if (state_q[i] == StReq && !grant_i[i]) begin
            if (wait_q[i] == WaitW'(TIMEOUT - 1)) begin
               timed_out[i] = 1'b1;
            end else begin
               wait_d[i] = wait_q[i] + WaitW'(1);
            end
         end
      end
      tout_d = tout_q | timed_out;
   end

   // Wait counters and sticky timeout flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tout_q <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            wait_q[i] <= '0;
         end
      end else begin
         tout_q <= tout_d;
         for (int i = 0; i < NUM_REQ; i++) begin
            wait_q[i] <= wait_d[i];
         end
      end
   end

   assign timeout_err_o = tout_q;
`else
   assign timed_out     = '0;
   assign timeout_err_o = '0;
`endif

   // Per-channel next state, remaining-beat and gap counters, and grant legality.
   always_comb begin
      proto_err_d = proto_err_q | multi_hot;
      request_d   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         state_d[i] = state_q[i];
         rem_d[i]   = rem_q[i];
         gap_d[i]   = gap_q[i];
         unique case (state_q[i])
            StIdle: begin
               if (grant_i[i]) begin
                  proto_err_d = 1'b1;
               end
               if (job_valid_i[i]) begin
                  state_d[i] = StReq;
                  rem_d[i]   = job_len_i[i*LEN_W +: LEN_W];
               end
            end
            StReq: begin
               if (grant_i[i]) begin
                  state_d[i] = StBusy;
               end else if (timed_out[i]) begin
                  state_d[i] = StGap;
                  gap_d[i]   = '0;
               end
            end
            StBusy: begin
               if (grant_i[i]) begin
                  if (rem_q[i] == '0) begin
                     state_d[i] = StGap;
                     gap_d[i]   = '0;
                  end else begin
                     rem_d[i] = rem_q[i] - LEN_W'(1);
                  end
               end else begin
                  // Preempted: keep the remaining count and re-request.
                  state_d[i] = StReq;
               end
            end
            StGap: begin
               // The arbiter gets the first gap cycle to withdraw its grant.
               if (grant_i[i] && gap_q[i] != '0) begin
                  proto_err_d = 1'b1;
               end
               if (gap_q[i] == GapW'(MIN_GAP - 1)) begin
                  state_d[i] = StIdle;
               end else begin
                  gap_d[i] = gap_q[i] + GapW'(1);
               end
            end
            default: state_d[i] = StIdle;
         endcase
         request_d[i] = (state_d[i] == StReq) || (state_d[i] == StBusy);
      end
   end

   // State, counters, registered request and sticky protocol error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         request_q   <= '0;
         proto_err_q <= 1'b0;
         for (int i = 0; i < NUM_REQ; i++) begin
            state_q[i] <= StIdle;
            rem_q[i]   <= '0;
            gap_q[i]   <= '0;
         end
      end else begin
         request_q   <= request_d;
         proto_err_q <= proto_err_d;
         for (int i = 0; i < NUM_REQ; i++) begin
            state_q[i] <= state_d[i];
            rem_q[i]   <= rem_d[i];
            gap_q[i]   <= gap_d[i];
         end
      end
   end

   // Outputs decoded from state; beats only happen while BUSY and granted.
   always_comb begin
      job_ready_o = '0;
      beat_en_o   = '0;
      done_o      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         job_ready_o[i] = (state_q[i] == StIdle);
         beat_en_o[i]   = (state_q[i] == StBusy) && grant_i[i];
         done_o[i]      = (state_q[i] == StBusy) && grant_i[i] && (rem_q[i] == '0);
      end
   end

   assign request_o   = request_q;
   assign proto_err_o = proto_err_q;

endmodule
